// File: rtl/memory_port_scheduler.sv
// Shares one memory command port between REQ_N requesters (0 = fixed priority, others round-robin
// with a starvation override) and routes in-order memory responses back through an ID FIFO.
module memory_port_scheduler #(
  parameter int REQ_N        = 3,
  parameter int ID_W         = 2,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_DEPTH_N = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  iCLOCK,
  input  logic                  iRESET,
  input  logic [REQ_N-1:0]      iREQ_VALID,
  output logic [REQ_N-1:0]      oREQ_LOCK,
  input  logic [REQ_N-1:0]      iREQ_RW,
  input  logic [4*REQ_N-1:0]    iREQ_MASK,
  input  logic [32*REQ_N-1:0]   iREQ_ADDR,
  input  logic [32*REQ_N-1:0]   iREQ_DATA,
  output logic                  oMEMORY_REQ,
  input  logic                  iMEMORY_LOCK,
  output logic                  oMEMORY_RW,
  output logic [3:0]            oMEMORY_MASK,
  output logic [31:0]           oMEMORY_ADDR,
  output logic [31:0]           oMEMORY_DATA,
  input  logic                  iMEMORY_VALID,
  input  logic                  iMEMORY_STORE_ACK,
  input  logic [63:0]           iMEMORY_DATA,
  output logic                  oMEMORY_BUSY,
  output logic [REQ_N-1:0]      oRESP_VALID,
  input  logic [REQ_N-1:0]      iRESP_BUSY,
  output logic                  oRESP_STORE_ACK,
  output logic [63:0]           oRESP_DATA,
  output logic                  oERROR
);

  // Per-requester views of the packed command buses
  logic [3:0]  req_mask [REQ_N];
  logic [31:0] req_addr [REQ_N];
  logic [31:0] req_data [REQ_N];

  logic [REQ_N-1:0] starve_hit;
  logic [REQ_N-1:0] rr_hi;
  logic [REQ_N-1:0] rr_lo;
  logic [ID_W-1:0]  rr_ptr_reg;
  logic [ID_W-1:0]  rr_ptr_next;
  logic [ID_W-1:0]  winner;
  logic             issue_ok;
  logic             accept;

  logic                    mem_req_reg;
  logic                    mem_rw_reg;
  logic [3:0]              mem_mask_reg;
  logic [31:0]             mem_addr_reg;
  logic [31:0]             mem_data_reg;

  logic [ID_W-1:0]         fifo_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_N-1:0] wr_ptr_reg;
  logic [FIFO_DEPTH_N-1:0] rd_ptr_reg;
  logic [FIFO_DEPTH_N:0]   fifo_cnt_reg;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [ID_W-1:0]         head_id;

  logic                    resp_full_reg;
  logic [ID_W-1:0]         resp_id_reg;
  logic                    resp_ack_reg;
  logic [63:0]             resp_data_reg;
  logic                    resp_busy;
  logic                    resp_accept;
  logic                    error_reg;

  function automatic logic [ID_W-1:0] lowest_set(input logic [REQ_N-1:0] vec);
    lowest_set = '0;
    for (int k = REQ_N - 1; k >= 0; k--) begin
      if (vec[k]) lowest_set = ID_W'(k);
    end
  endfunction

  generate
    for (genvar gi = 0; gi < REQ_N; gi++) begin : g_req
      assign req_mask[gi] = iREQ_MASK[4*gi +: 4];
      assign req_addr[gi] = iREQ_ADDR[32*gi +: 32];
      assign req_data[gi] = iREQ_DATA[32*gi +: 32];

      assign oREQ_LOCK[gi]   = !(issue_ok && (winner == ID_W'(gi)));
      assign oRESP_VALID[gi] = resp_full_reg && (resp_id_reg == ID_W'(gi)) && !iRESP_BUSY[gi];

      if (gi == 0) begin : g_prio
        assign starve_hit[gi] = 1'b0;
        assign rr_hi[gi]      = 1'b0;
        assign rr_lo[gi]      = 1'b0;
      end else begin : g_rr
        logic [7:0] starve_cnt_reg;

        // Saturating wait counter; any cycle not waiting restarts the count
        always_ff @(posedge iCLOCK or posedge iRESET) begin
          if (iRESET) begin
            starve_cnt_reg <= '0;
          end else if (!iREQ_VALID[gi] || (accept && (winner == ID_W'(gi)))) begin
            starve_cnt_reg <= '0;
          end else if (starve_cnt_reg != 8'hFF) begin
            starve_cnt_reg <= starve_cnt_reg + 8'd1;
          end
        end

        assign starve_hit[gi] = iREQ_VALID[gi] && (starve_cnt_reg >= 8'(STARVE_LIMIT));
        assign rr_hi[gi]      = iREQ_VALID[gi] && (ID_W'(gi) >= rr_ptr_reg);
        assign rr_lo[gi]      = iREQ_VALID[gi];
      end
    end
  endgenerate

  // Starved requester beats requester 0, which beats the round-robin pick
  always_comb begin
    winner = '0;
    if (|starve_hit) begin
      winner = lowest_set(starve_hit);
    end else if (iREQ_VALID[0]) begin
      winner = '0;
    end else if (|rr_hi) begin
      winner = lowest_set(rr_hi);
    end else begin
      winner = lowest_set(rr_lo);
    end
  end

  assign issue_ok = !iRESET && !iMEMORY_LOCK && !fifo_full && (|iREQ_VALID);
  assign accept   = issue_ok;

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (accept && (winner != '0)) begin
      rr_ptr_next = (winner == ID_W'(REQ_N - 1)) ? ID_W'(1) : winner + ID_W'(1);
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      rr_ptr_reg <= ID_W'(1);
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      mem_req_reg  <= 1'b0;
      mem_rw_reg   <= 1'b0;
      mem_mask_reg <= '0;
      mem_addr_reg <= '0;
      mem_data_reg <= '0;
    end else begin
      mem_req_reg <= accept;
      if (accept) begin
        mem_rw_reg   <= iREQ_RW[winner];
        mem_mask_reg <= req_mask[winner];
        mem_addr_reg <= req_addr[winner];
        mem_data_reg <= req_data[winner];
      end
    end
  end

  // ID FIFO: entries need no reset, only the pointers and occupancy do
  always_ff @(posedge iCLOCK) begin
    if (accept) begin
      fifo_mem[wr_ptr_reg] <= winner;
    end
  end

  assign head_id    = fifo_mem[rd_ptr_reg];
  assign fifo_full  = (fifo_cnt_reg == (FIFO_DEPTH_N + 1)'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt_reg == '0);

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
    end else begin
      if (accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (resp_accept) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({accept, resp_accept})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 1'b1;
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 1'b1;
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
    end
  end

  assign resp_busy   = resp_full_reg && iRESP_BUSY[resp_id_reg];
  assign resp_accept = iMEMORY_VALID && !resp_busy && !fifo_empty;

  // Response holding register: stays put while its target stalls
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      resp_full_reg <= 1'b0;
      resp_id_reg   <= '0;
      resp_ack_reg  <= 1'b0;
      resp_data_reg <= '0;
    end else if (resp_accept) begin
      resp_full_reg <= 1'b1;
      resp_id_reg   <= head_id;
      resp_ack_reg  <= iMEMORY_STORE_ACK;
      resp_data_reg <= iMEMORY_DATA;
    end else if (!resp_busy) begin
      resp_full_reg <= 1'b0;
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      error_reg <= 1'b0;
    end else if (iMEMORY_VALID && fifo_empty) begin
      error_reg <= 1'b1;
    end
  end

  assign oMEMORY_REQ     = mem_req_reg;
  assign oMEMORY_RW      = mem_rw_reg;
  assign oMEMORY_MASK    = mem_mask_reg;
  assign oMEMORY_ADDR    = mem_addr_reg;
  assign oMEMORY_DATA    = mem_data_reg;
  assign oMEMORY_BUSY    = resp_busy;
  assign oRESP_STORE_ACK = resp_full_reg && resp_ack_reg;
  assign oRESP_DATA      = resp_data_reg;
  assign oERROR          = error_reg;

endmodule

// File: tb/tb_memory_port_scheduler.sv
// Directed bench for memory_port_scheduler: arbitration order, starvation, FIFO full, store-ack,
// response stall, empty-FIFO error and asynchronous reset.
module tb_memory_port_scheduler;
  localparam int REQ_N = 3;

  logic                iCLOCK = 1'b0;
  logic                iRESET = 1'b1;
  logic [REQ_N-1:0]    iREQ_VALID = '0;
  logic [REQ_N-1:0]    oREQ_LOCK;
  logic [REQ_N-1:0]    iREQ_RW = '0;
  logic [4*REQ_N-1:0]  iREQ_MASK = '0;
  logic [32*REQ_N-1:0] iREQ_ADDR = '0;
  logic [32*REQ_N-1:0] iREQ_DATA = '0;
  logic                oMEMORY_REQ;
  logic                iMEMORY_LOCK = 1'b0;
  logic                oMEMORY_RW;
  logic [3:0]          oMEMORY_MASK;
  logic [31:0]         oMEMORY_ADDR;
  logic [31:0]         oMEMORY_DATA;
  logic                iMEMORY_VALID = 1'b0;
  logic                iMEMORY_STORE_ACK = 1'b0;
  logic [63:0]         iMEMORY_DATA = '0;
  logic                oMEMORY_BUSY;
  logic [REQ_N-1:0]    oRESP_VALID;
  logic [REQ_N-1:0]    iRESP_BUSY = '0;
  logic                oRESP_STORE_ACK;
  logic [63:0]         oRESP_DATA;
  logic                oERROR;

  int checks = 0;
  int errors = 0;

  memory_port_scheduler #(
    .REQ_N(3), .ID_W(2), .FIFO_DEPTH(16), .FIFO_DEPTH_N(4), .STARVE_LIMIT(8)
  ) dut (
    .iCLOCK(iCLOCK), .iRESET(iRESET),
    .iREQ_VALID(iREQ_VALID), .oREQ_LOCK(oREQ_LOCK), .iREQ_RW(iREQ_RW),
    .iREQ_MASK(iREQ_MASK), .iREQ_ADDR(iREQ_ADDR), .iREQ_DATA(iREQ_DATA),
    .oMEMORY_REQ(oMEMORY_REQ), .iMEMORY_LOCK(iMEMORY_LOCK), .oMEMORY_RW(oMEMORY_RW),
    .oMEMORY_MASK(oMEMORY_MASK), .oMEMORY_ADDR(oMEMORY_ADDR), .oMEMORY_DATA(oMEMORY_DATA),
    .iMEMORY_VALID(iMEMORY_VALID), .iMEMORY_STORE_ACK(iMEMORY_STORE_ACK),
    .iMEMORY_DATA(iMEMORY_DATA), .oMEMORY_BUSY(oMEMORY_BUSY),
    .oRESP_VALID(oRESP_VALID), .iRESP_BUSY(iRESP_BUSY),
    .oRESP_STORE_ACK(oRESP_STORE_ACK), .oRESP_DATA(oRESP_DATA), .oERROR(oERROR)
  );

  always #5 iCLOCK = ~iCLOCK;

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic clear_inputs();
    iREQ_VALID = '0; iREQ_RW = '0; iREQ_MASK = '0; iREQ_ADDR = '0; iREQ_DATA = '0;
    iMEMORY_LOCK = 1'b0; iMEMORY_VALID = 1'b0; iMEMORY_STORE_ACK = 1'b0;
    iMEMORY_DATA = '0; iRESP_BUSY = '0;
  endtask

  task automatic set_req(input int idx, input logic rw, input logic [3:0] mask,
                         input logic [31:0] addr, input logic [31:0] data);
    iREQ_RW[idx] = rw;
    iREQ_MASK[4*idx +: 4] = mask;
    iREQ_ADDR[32*idx +: 32] = addr;
    iREQ_DATA[32*idx +: 32] = data;
  endtask

  task automatic pulse_reset();
    clear_inputs();
    iRESET = 1'b1;
    tick();
    iRESET = 1'b0;
  endtask

  task automatic test_reset();
    iREQ_VALID = 3'b111;
    repeat (2) @(posedge iCLOCK);
    @(negedge iCLOCK);
    checks++;
    if (oREQ_LOCK !== 3'b111) begin errors++; $display("FAIL reset_lock got=%b exp=111", oREQ_LOCK); end
    checks++;
    if (oMEMORY_REQ !== 1'b0 || oRESP_VALID !== 3'b000 || oMEMORY_BUSY !== 1'b0) begin
      errors++; $display("FAIL reset_outputs req=%b resp=%b busy=%b exp=0/000/0", oMEMORY_REQ, oRESP_VALID, oMEMORY_BUSY);
    end
    checks++;
    if (oERROR !== 1'b0 || oRESP_STORE_ACK !== 1'b0) begin
      errors++; $display("FAIL reset_flags err=%b ack=%b exp=0/0", oERROR, oRESP_STORE_ACK);
    end
    $display("reset: lock=%b req=%b", oREQ_LOCK, oMEMORY_REQ);
    tick();
    clear_inputs();
    iRESET = 1'b0;
  endtask

  task automatic test_basic_read();
    set_req(1, 1'b0, 4'hF, 32'h0000_1000, 32'h0);
    iREQ_VALID = 3'b010;
    @(negedge iCLOCK);
    checks++;
    if (oREQ_LOCK !== 3'b101) begin errors++; $display("FAIL basic_lock got=%b exp=101", oREQ_LOCK); end
    tick();
    iREQ_VALID = '0;
    @(negedge iCLOCK);
    checks++;
    if (oMEMORY_REQ !== 1'b1 || oMEMORY_ADDR !== 32'h1000 || oMEMORY_RW !== 1'b0 || oMEMORY_MASK !== 4'hF) begin
      errors++; $display("FAIL basic_cmd req=%b addr=%h rw=%b mask=%h exp=1/1000/0/f",
                         oMEMORY_REQ, oMEMORY_ADDR, oMEMORY_RW, oMEMORY_MASK);
    end
    tick();
    iMEMORY_VALID = 1'b1;
    iMEMORY_DATA = 64'h0000_0000_DEAD_BEEF;
    @(negedge iCLOCK);
    checks++;
    if (oMEMORY_REQ !== 1'b0 || oRESP_VALID !== 3'b000) begin
      errors++; $display("FAIL basic_idle req=%b resp=%b exp=0/000", oMEMORY_REQ, oRESP_VALID);
    end
    tick();
    iMEMORY_VALID = 1'b0;
    @(negedge iCLOCK);
    checks++;
    if (oRESP_VALID !== 3'b010 || oRESP_DATA !== 64'h0000_0000_DEAD_BEEF || oRESP_STORE_ACK !== 1'b0) begin
      errors++; $display("FAIL basic_resp valid=%b data=%h ack=%b exp=010/deadbeef/0", oRESP_VALID, oRESP_DATA, oRESP_STORE_ACK);
    end
    $display("basic: resp_valid=%b data=%h", oRESP_VALID, oRESP_DATA);
    tick();
    @(negedge iCLOCK);
    checks++;
    if (oRESP_VALID !== 3'b000) begin errors++; $display("FAIL basic_resp_clear got=%b exp=000", oRESP_VALID); end
    tick();
  endtask

  task automatic test_starvation();
    int exp_grant [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0};
    logic [2:0]  exp_lock;
    logic [31:0] exp_addr;
    pulse_reset();
    set_req(0, 1'b0, 4'hF, 32'h100, 32'h0);
    set_req(1, 1'b0, 4'hF, 32'h200, 32'h0);
    set_req(2, 1'b0, 4'hF, 32'h300, 32'h0);
    iREQ_VALID = 3'b111;
    for (int c = 0; c < 14; c++) begin
      @(negedge iCLOCK);
      exp_lock = ~(3'b001 << exp_grant[c]);
      checks++;
      if (oREQ_LOCK !== exp_lock) begin
        errors++; $display("FAIL starve_grant cycle=%0d got=%b exp=%b", c, oREQ_LOCK, exp_lock);
      end
      if (c > 0) begin
        exp_addr = 32'h100 * 32'(exp_grant[c-1] + 1);
        checks++;
        if (oMEMORY_ADDR !== exp_addr || oMEMORY_REQ !== 1'b1) begin
          errors++; $display("FAIL starve_cmd cycle=%0d addr=%h req=%b exp=%h/1", c, oMEMORY_ADDR, oMEMORY_REQ, exp_addr);
        end
      end
      $display("starve: cycle %0d lock=%b", c, oREQ_LOCK);
      tick();
    end
    iREQ_VALID = '0;
  endtask

  task automatic test_round_robin();
    int exp_grant [6] = '{1, 2, 1, 2, 1, 2};
    logic [2:0] exp_lock;
    pulse_reset();
    set_req(1, 1'b0, 4'hF, 32'h200, 32'h0);
    set_req(2, 1'b0, 4'hF, 32'h300, 32'h0);
    iREQ_VALID = 3'b110;
    for (int c = 0; c < 6; c++) begin
      @(negedge iCLOCK);
      exp_lock = ~(3'b001 << exp_grant[c]);
      checks++;
      if (oREQ_LOCK !== exp_lock) begin
        errors++; $display("FAIL rr_grant cycle=%0d got=%b exp=%b", c, oREQ_LOCK, exp_lock);
      end
      $display("rr: cycle %0d lock=%b", c, oREQ_LOCK);
      tick();
    end
    iREQ_VALID = '0;
  endtask

  task automatic test_fifo_full();
    logic [2:0] exp_lock;
    logic [2:0] exp_valid;
    int exp_id;
    pulse_reset();
    for (int i = 0; i < 16; i++) begin
      iREQ_VALID = '0;
      set_req(i % 3, 1'b0, 4'hF, 32'h4000 + 32'(i * 4), 32'h0);
      iREQ_VALID = 3'b001 << (i % 3);
      @(negedge iCLOCK);
      exp_lock = ~(3'b001 << (i % 3));
      checks++;
      if (oREQ_LOCK !== exp_lock) begin
        errors++; $display("FAIL fill_lock i=%0d got=%b exp=%b", i, oREQ_LOCK, exp_lock);
      end
      tick();
    end
    iREQ_VALID = 3'b111;
    @(negedge iCLOCK);
    checks++;
    if (oREQ_LOCK !== 3'b111) begin errors++; $display("FAIL full_lock got=%b exp=111", oREQ_LOCK); end
    tick();
    iMEMORY_VALID = 1'b1;
    iMEMORY_DATA = 64'hA5;
    @(negedge iCLOCK);
    checks++;
    if (oREQ_LOCK !== 3'b111) begin errors++; $display("FAIL full_pop_lock got=%b exp=111", oREQ_LOCK); end
    tick();
    iMEMORY_VALID = 1'b0;
    @(negedge iCLOCK);
    checks++;
    if (oREQ_LOCK !== 3'b110) begin errors++; $display("FAIL full_release got=%b exp=110", oREQ_LOCK); end
    checks++;
    if (oRESP_VALID !== 3'b001 || oRESP_DATA !== 64'hA5) begin
      errors++; $display("FAIL full_first_resp valid=%b data=%h exp=001/a5", oRESP_VALID, oRESP_DATA);
    end
    tick();
    iREQ_VALID = '0;
    for (int k = 0; k <= 16; k++) begin
      iMEMORY_VALID = (k < 16);
      iMEMORY_DATA = 64'(k);
      @(negedge iCLOCK);
      if (k > 0) begin
        exp_id = (k - 1 < 15) ? (k % 3) : 0;
        exp_valid = 3'b001 << exp_id;
        checks++;
        if (oRESP_VALID !== exp_valid || oRESP_DATA !== 64'(k - 1)) begin
          errors++; $display("FAIL drain_order k=%0d valid=%b data=%0d exp=%b/%0d", k, oRESP_VALID, oRESP_DATA, exp_valid, k - 1);
        end
        $display("drain: response %0d -> valid=%b", k - 1, oRESP_VALID);
      end
      tick();
    end
    @(negedge iCLOCK);
    checks++;
    if (oERROR !== 1'b0) begin errors++; $display("FAIL drain_error got=%b exp=0", oERROR); end
    tick();
  endtask

  task automatic test_store_busy();
    set_req(0, 1'b1, 4'h3, 32'h0000_2000, 32'hCAFE_F00D);
    iREQ_VALID = 3'b001;
    @(negedge iCLOCK);
    checks++;
    if (oREQ_LOCK !== 3'b110) begin errors++; $display("FAIL store_lock got=%b exp=110", oREQ_LOCK); end
    tick();
    iREQ_VALID = '0;
    iREQ_RW = '0;
    @(negedge iCLOCK);
    checks++;
    if (oMEMORY_REQ !== 1'b1 || oMEMORY_RW !== 1'b1 || oMEMORY_DATA !== 32'hCAFE_F00D ||
        oMEMORY_MASK !== 4'h3 || oMEMORY_ADDR !== 32'h2000) begin
      errors++; $display("FAIL store_cmd req=%b rw=%b data=%h mask=%h addr=%h exp=1/1/cafef00d/3/2000",
                         oMEMORY_REQ, oMEMORY_RW, oMEMORY_DATA, oMEMORY_MASK, oMEMORY_ADDR);
    end
    tick();
    iRESP_BUSY = 3'b001;
    iMEMORY_VALID = 1'b1;
    iMEMORY_STORE_ACK = 1'b1;
    @(negedge iCLOCK);
    checks++;
    if (oMEMORY_BUSY !== 1'b0) begin errors++; $display("FAIL store_busy_pre got=%b exp=0", oMEMORY_BUSY); end
    tick();
    iMEMORY_VALID = 1'b0;
    iMEMORY_STORE_ACK = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge iCLOCK);
      checks++;
      if (oMEMORY_BUSY !== 1'b1 || oRESP_VALID !== 3'b000) begin
        errors++; $display("FAIL store_stall j=%0d busy=%b valid=%b exp=1/000", j, oMEMORY_BUSY, oRESP_VALID);
      end
      $display("store: stall cycle %0d busy=%b", j, oMEMORY_BUSY);
      if (j < 2) tick();
    end
    tick();
    iRESP_BUSY = '0;
    @(negedge iCLOCK);
    checks++;
    if (oRESP_VALID !== 3'b001 || oRESP_STORE_ACK !== 1'b1 || oMEMORY_BUSY !== 1'b0) begin
      errors++; $display("FAIL store_deliver valid=%b ack=%b busy=%b exp=001/1/0", oRESP_VALID, oRESP_STORE_ACK, oMEMORY_BUSY);
    end
    tick();
    @(negedge iCLOCK);
    checks++;
    if (oRESP_VALID !== 3'b000) begin errors++; $display("FAIL store_clear got=%b exp=000", oRESP_VALID); end
    tick();
  endtask

  task automatic test_error_and_reset();
    iMEMORY_VALID = 1'b1;
    iMEMORY_DATA = 64'h77;
    @(negedge iCLOCK);
    tick();
    iMEMORY_VALID = 1'b0;
    @(negedge iCLOCK);
    checks++;
    if (oRESP_VALID !== 3'b000 || oERROR !== 1'b1) begin
      errors++; $display("FAIL empty_resp valid=%b err=%b exp=000/1", oRESP_VALID, oERROR);
    end
    tick();
    set_req(1, 1'b0, 4'hF, 32'h500, 32'h0);
    set_req(2, 1'b0, 4'hF, 32'h600, 32'h0);
    iREQ_VALID = 3'b110;
    tick();
    tick();
    @(negedge iCLOCK);
    #1;
    iRESET = 1'b1;
    #1;
    checks++;
    if (oERROR !== 1'b0 || oMEMORY_REQ !== 1'b0 || oREQ_LOCK !== 3'b111 || oRESP_VALID !== 3'b000) begin
      errors++; $display("FAIL midburst_reset err=%b req=%b lock=%b valid=%b exp=0/0/111/000",
                         oERROR, oMEMORY_REQ, oREQ_LOCK, oRESP_VALID);
    end
    @(posedge iCLOCK);
    #1;
    clear_inputs();
    iRESET = 1'b0;
    iMEMORY_VALID = 1'b1;
    iMEMORY_DATA = 64'h99;
    @(negedge iCLOCK);
    tick();
    iMEMORY_VALID = 1'b0;
    @(negedge iCLOCK);
    checks++;
    if (oRESP_VALID !== 3'b000 || oERROR !== 1'b1) begin
      errors++; $display("FAIL fifo_cleared valid=%b err=%b exp=000/1", oRESP_VALID, oERROR);
    end
    $display("error: after reset resp=%b err=%b", oRESP_VALID, oERROR);
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_starvation();
    test_round_robin();
    test_fifo_full();
    test_store_busy();
    test_error_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
